// File: rtl/maze_pkg.sv
// Shared maze-game definitions: controller state encoding, direction codes and
// the default grid, start and goal constants also used by the renderer.
package maze_pkg;

  typedef logic [2:0] state_t;
  typedef logic [1:0] dir_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CALC  = 3'd1;
  localparam state_t ST_READ  = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_CHECK = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  localparam dir_t DIR_L = 2'd0;
  localparam dir_t DIR_R = 2'd1;
  localparam dir_t DIR_U = 2'd2;
  localparam dir_t DIR_D = 2'd3;

  localparam int GRID_X_BITS = 3;
  localparam int GRID_Y_BITS = 3;
  localparam int START_X_DEF = 1;
  localparam int START_Y_DEF = 1;
  localparam int GOAL_X_DEF  = 6;
  localparam int GOAL_Y_DEF  = 6;

  // Horizontal moves beat vertical ones; with no direction set the result is DIR_D.
  function automatic dir_t dir_pick(input logic l, input logic r, input logic u, input logic d);
    dir_t res;
    if (l) begin
      res = DIR_L;
    end else if (r) begin
      res = DIR_R;
    end else if (u) begin
      res = DIR_U;
    end else begin
      res = d ? DIR_D : DIR_D;
    end
    return res;
  endfunction

endpackage

// File: rtl/move_target.sv
// Combinational single-step target calculator with grid bounds check; shared by
// the player controller and the ghost controller.
module move_target
  import maze_pkg::*;
#(
  parameter int X_BITS = GRID_X_BITS,
  parameter int Y_BITS = GRID_Y_BITS,
  parameter int X_MIN  = 0,
  parameter int X_MAX  = (1 << X_BITS) - 1,
  parameter int Y_MIN  = 0,
  parameter int Y_MAX  = (1 << Y_BITS) - 1
) (
  input  logic              dir_l_i,
  input  logic              dir_r_i,
  input  logic              dir_u_i,
  input  logic              dir_d_i,
  input  logic [X_BITS-1:0] pos_x_i,
  input  logic [Y_BITS-1:0] pos_y_i,
  output logic [X_BITS-1:0] tgt_x_o,
  output logic [Y_BITS-1:0] tgt_y_o,
  output logic              in_bounds_o
);

  localparam logic signed [X_BITS:0] X_LO = (X_BITS+1)'(X_MIN);
  localparam logic signed [X_BITS:0] X_HI = (X_BITS+1)'(X_MAX);
  localparam logic signed [Y_BITS:0] Y_LO = (Y_BITS+1)'(Y_MIN);
  localparam logic signed [Y_BITS:0] Y_HI = (Y_BITS+1)'(Y_MAX);
  localparam logic signed [X_BITS:0] X_ONE = (X_BITS+1)'(1);
  localparam logic signed [Y_BITS:0] Y_ONE = (Y_BITS+1)'(1);

  logic signed [X_BITS:0] tx_s;
  logic signed [Y_BITS:0] ty_s;

  // One bit of headroom so 0-1 and MAX+1 land outside the legal range instead of wrapping.
  always_comb begin
    tx_s = $signed({1'b0, pos_x_i});
    ty_s = $signed({1'b0, pos_y_i});
    case (dir_pick(dir_l_i, dir_r_i, dir_u_i, dir_d_i))
      DIR_L:   tx_s = tx_s - X_ONE;
      DIR_R:   tx_s = tx_s + X_ONE;
      DIR_U:   ty_s = ty_s - Y_ONE;
      DIR_D:   ty_s = ty_s + Y_ONE;
      default: tx_s = tx_s;
    endcase
    in_bounds_o = (tx_s >= X_LO) && (tx_s <= X_HI) && (ty_s >= Y_LO) && (ty_s <= Y_HI);
    tgt_x_o     = tx_s[X_BITS-1:0];
    tgt_y_o     = ty_s[Y_BITS-1:0];
  end

endmodule

// File: rtl/player_move_ctrl.sv
// Player movement controller: one move per request, bounds and wall check via the
// maze-map RAM, commit on legal moves, lock once the goal cell is reached.
module player_move_ctrl
  import maze_pkg::*;
#(
  parameter int X_BITS   = GRID_X_BITS,
  parameter int Y_BITS   = GRID_Y_BITS,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = (1 << X_BITS) - 1,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = (1 << Y_BITS) - 1,
  parameter int START_X  = START_X_DEF,
  parameter int START_Y  = START_Y_DEF,
  parameter int GOAL_X   = GOAL_X_DEF,
  parameter int GOAL_Y   = GOAL_Y_DEF,
  parameter int MAP_LAT  = 1,
  parameter int CNT_BITS = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     move_req,
  input  logic                     move_left,
  input  logic                     move_right,
  input  logic                     move_up,
  input  logic                     move_down,
  output logic                     map_rd,
  output logic [X_BITS+Y_BITS-1:0] map_addr,
  input  logic                     map_wall,
  output logic [X_BITS-1:0]        pos_x,
  output logic [Y_BITS-1:0]        pos_y,
  output logic                     busy,
  output logic                     move_done,
  output logic                     move_legal,
  output logic                     goal_reached,
  output logic [CNT_BITS-1:0]      move_count
);

  localparam int WAIT_W = (MAP_LAT > 2) ? $clog2(MAP_LAT - 1) : 1;
  localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'((MAP_LAT > 1) ? (MAP_LAT - 2) : 0);
  localparam logic [CNT_BITS-1:0] CNT_SAT   = {CNT_BITS{1'b1}};
  localparam logic [X_BITS-1:0]   GOAL_XV   = X_BITS'(GOAL_X);
  localparam logic [Y_BITS-1:0]   GOAL_YV   = Y_BITS'(GOAL_Y);

  state_t                     state_q, state_d;
  logic [3:0]                 dirs_q, dirs_d;
  logic [X_BITS-1:0]          tx_q, tx_d, pos_x_q, pos_x_d, tgt_x_s;
  logic [Y_BITS-1:0]          ty_q, ty_d, pos_y_q, pos_y_d, tgt_y_s;
  logic [WAIT_W-1:0]          wcnt_q, wcnt_d;
  logic                       map_rd_q, map_rd_d, busy_q, busy_d, done_q, done_d;
  logic                       legal_q, legal_d, goal_q, goal_d, in_bounds_s;
  logic [X_BITS+Y_BITS-1:0]   addr_q, addr_d;
  logic [CNT_BITS-1:0]        cnt_q, cnt_d;

  move_target #(
    .X_BITS(X_BITS), .Y_BITS(Y_BITS),
    .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)
  ) u_target (
    .dir_l_i    (dirs_q[3]),
    .dir_r_i    (dirs_q[2]),
    .dir_u_i    (dirs_q[1]),
    .dir_d_i    (dirs_q[0]),
    .pos_x_i    (pos_x_q),
    .pos_y_i    (pos_y_q),
    .tgt_x_o    (tgt_x_s),
    .tgt_y_o    (tgt_y_s),
    .in_bounds_o(in_bounds_s)
  );

  // Next-state logic; outputs are registered, so strobes are raised on entry to their state.
  always_comb begin
    state_d  = state_q;
    dirs_d   = dirs_q;
    tx_d     = tx_q;
    ty_d     = ty_q;
    wcnt_d   = wcnt_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    map_rd_d = 1'b0;
    done_d   = 1'b0;
    legal_d  = legal_q;
    goal_d   = goal_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (move_req && !goal_q && (move_left || move_right || move_up || move_down)) begin
          dirs_d  = {move_left, move_right, move_up, move_down};
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        tx_d = tgt_x_s;
        ty_d = tgt_y_s;
        if (in_bounds_s) begin
          map_rd_d = 1'b1;
          addr_d   = {tgt_y_s, tgt_x_s};
          state_d  = ST_READ;
        end else begin
          done_d  = 1'b1;
          legal_d = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_READ: begin
        wcnt_d = '0;
        if (MAP_LAT == 1) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          state_d = ST_CHECK;
        end else begin
          wcnt_d = wcnt_q + WAIT_W'(1);
        end
      end
      ST_CHECK: begin
        legal_d = !map_wall;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (legal_q) begin
          pos_x_d = tx_q;
          pos_y_d = ty_q;
          cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : (cnt_q + CNT_BITS'(1));
          goal_d  = goal_q || ((tx_q == GOAL_XV) && (ty_q == GOAL_YV));
        end else begin
          pos_x_d = pos_x_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any move in flight without committing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      dirs_q   <= 4'b0000;
      tx_q     <= '0;
      ty_q     <= '0;
      wcnt_q   <= '0;
      pos_x_q  <= X_BITS'(START_X);
      pos_y_q  <= Y_BITS'(START_Y);
      map_rd_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      legal_q  <= 1'b0;
      goal_q   <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      dirs_q   <= dirs_d;
      tx_q     <= tx_d;
      ty_q     <= ty_d;
      wcnt_q   <= wcnt_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      map_rd_q <= map_rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      legal_q  <= legal_d;
      goal_q   <= goal_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign map_rd       = map_rd_q;
  assign map_addr     = addr_q;
  assign pos_x        = pos_x_q;
  assign pos_y        = pos_y_q;
  assign busy         = busy_q;
  assign move_done    = done_q;
  assign move_legal   = legal_q;
  assign goal_reached = goal_q;
  assign move_count   = cnt_q;

endmodule
